// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue path: op encodings,
// issue FSM state encoding and the default operand width.
package md_pkg;

    localparam int MD_WIDTH = 16;

    // Op encoding is {signed, md}: md selects mult (0) or div (1).
    localparam logic [1:0] MD_OP_MULTU = 2'b00;
    localparam logic [1:0] MD_OP_DIVU  = 2'b01;
    localparam logic [1:0] MD_OP_MULT  = 2'b10;
    localparam logic [1:0] MD_OP_DIV   = 2'b11;

    typedef logic [1:0] md_state_t;

    localparam md_state_t ST_IDLE  = 2'd0;
    localparam md_state_t ST_ISSUE = 2'd1;
    localparam md_state_t ST_GUARD = 2'd2;
    localparam md_state_t ST_WAIT  = 2'd3;

endpackage

// File: rtl/md_req_fifo.sv
// Small request FIFO: power-of-two depth, wrapping pointers, occupancy count,
// flush drops every unread entry. Head data is read combinationally.
module md_req_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok;
    logic          pop_ok;

    // Flush wins over a same-cycle push; a same-cycle pop has already been consumed.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= tail_reg;
            count_reg <= '0;
        end else begin
            if (push_ok) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop_ok) begin
                head_reg <= head_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign rdata = mem[head_reg];
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/md_issue_queue.sv
// Buffers mult/div requests and issues them one at a time to the MD unit.
// Define MDQ_BYPASS_EN to let a request skip the FIFO when everything is idle.
module md_issue_queue
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [WIDTH-1:0]             req_d1,
    input  logic [WIDTH-1:0]             req_d2,
    input  logic                         flush,
    output logic                         md_start,
    output logic [1:0]                   md_op,
    output logic [WIDTH-1:0]             md_d1,
    output logic [WIDTH-1:0]             md_d2,
    input  logic                         md_busy,
    output logic                         hilo_stall,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);
    localparam int EW = 2 + 2*WIDTH;
    localparam int CW = $clog2(DEPTH+1);

    md_state_t        state_reg;
    logic [EW-1:0]    head_entry;
    logic [CW-1:0]    count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             bypass;
    logic             load;
    logic [1:0]       load_op;
    logic [WIDTH-1:0] load_d1;
    logic [WIDTH-1:0] load_d2;

    assign req_ready = !fifo_full;
    assign pop       = (state_reg == ST_IDLE) && !fifo_empty && !md_busy;

`ifdef MDQ_BYPASS_EN
    assign bypass = (state_reg == ST_IDLE) && (count == '0) && !md_busy && req_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = req_valid && req_ready && !bypass;
    assign load = pop || bypass;
    assign {load_op, load_d1, load_d2} = bypass ? {req_op, req_d1, req_d2} : head_entry;

    md_req_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({req_op, req_d1, req_d2}),
        .rdata (head_entry),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // GUARD gives the MD unit a cycle to raise busy before WAIT samples it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            md_op     <= '0;
            md_d1     <= '0;
            md_d2     <= '0;
        end else begin
            if (load) begin
                md_op <= load_op;
                md_d1 <= load_d1;
                md_d2 <= load_d2;
            end
            case (state_reg)
                ST_IDLE:  if (load) state_reg <= ST_ISSUE;
                ST_ISSUE: state_reg <= ST_GUARD;
                ST_GUARD: state_reg <= ST_WAIT;
                ST_WAIT:  if (!md_busy) state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign md_start   = (state_reg == ST_ISSUE);
    assign hilo_stall = (count != '0) || (state_reg != ST_IDLE) || md_busy;
    assign q_count    = count;

endmodule

// File: tb/tb_md_issue_queue.sv
// Directed bench for md_issue_queue with a simple MD-unit busy model.
module tb_md_issue_queue;
    import md_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [WIDTH-1:0] req_d1 = '0;
    logic [WIDTH-1:0] req_d2 = '0;
    logic             flush = 1'b0;
    logic             md_start;
    logic [1:0]       md_op;
    logic [WIDTH-1:0] md_d1;
    logic [WIDTH-1:0] md_d2;
    logic             md_busy;
    logic             hilo_stall;
    logic [1:0]       q_count;

    int   checks = 0;
    int   errors = 0;
    int   busy_left;
    int   busy_len = 5;
    logic busy_force = 1'b0;

    md_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_d1     (req_d1),
        .req_d2     (req_d2),
        .flush      (flush),
        .md_start   (md_start),
        .md_op      (md_op),
        .md_d1      (md_d1),
        .md_d2      (md_d2),
        .md_busy    (md_busy),
        .hilo_stall (hilo_stall),
        .q_count    (q_count)
    );

    always #5 clk = ~clk;

    // MD unit model: busy for busy_len cycles after it sees Start.
    always @(posedge clk or negedge reset) begin
        if (!reset)               busy_left <= 0;
        else if (md_start)        busy_left <= busy_len;
        else if (busy_left > 0)   busy_left <= busy_left - 1;
    end
    assign md_busy = busy_force | (busy_left != 0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL reset_md_start got %b exp 0", md_start); end
        checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL reset_q_count got %0d exp 0", q_count); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (hilo_stall !== 1'b0) begin errors++; $display("FAIL reset_hilo_stall got %b exp 0", hilo_stall); end
        checks++; if ({md_op, md_d1, md_d2} !== 34'd0) begin errors++; $display("FAIL reset_md_regs got %h exp 0", {md_op, md_d1, md_d2}); end
        reset = 1'b1;
        tick();
        $display("reset: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single();
        int n;
        int extra;
        busy_len = 5;
        req_valid = 1'b1; req_op = MD_OP_DIVU; req_d1 = 16'h0064; req_d2 = 16'h0007;
        tick();
        req_valid = 1'b0;
`ifdef MDQ_BYPASS_EN
        checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL single_bypass_start got %b exp 1", md_start); end
        checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL single_bypass_count got %0d exp 0", q_count); end
`else
        checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL single_early_start got %b exp 0", md_start); end
        checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL single_enq_count got %0d exp 1", q_count); end
        checks++; if (hilo_stall !== 1'b1) begin errors++; $display("FAIL single_stall_queued got %b exp 1", hilo_stall); end
        tick();
        checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", md_start); end
`endif
        checks++; if (md_op !== 2'b01) begin errors++; $display("FAIL single_md_op got %b exp 01", md_op); end
        checks++; if (md_d1 !== 16'h0064) begin errors++; $display("FAIL single_md_d1 got %h exp 0064", md_d1); end
        checks++; if (md_d2 !== 16'h0007) begin errors++; $display("FAIL single_md_d2 got %h exp 0007", md_d2); end
        tick();
        checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b exp 0", md_start); end
        n = 0; extra = 0;
        while (hilo_stall && n < 20) begin
            tick(); n++;
            if (md_start) extra++;
        end
        checks++; if (n !== 6) begin errors++; $display("FAIL single_stall_cycles got %0d exp 6", n); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL single_extra_start got %0d exp 0", extra); end
        $display("single: stall released after %0d cycles", n);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] got_d1 [3];
        int               got_cyc [3];
        int               ns;
        int               cyc;
        int               early;
        logic             accepted;
        logic             c_taken;
        busy_len = 5; busy_force = 1'b1; early = 0;
        req_valid = 1'b1; req_op = MD_OP_MULT; req_d2 = 16'h0001;
        req_d1 = 16'h000A; tick(); early += int'(md_start);
        req_d1 = 16'h000B; tick(); early += int'(md_start);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b exp 0", req_ready); end
        req_d1 = 16'h000C; tick(); early += int'(md_start);
        checks++; if (q_count !== 2'd2) begin errors++; $display("FAIL b2b_count_held got %0d exp 2", q_count); end
        checks++; if (early !== 0) begin errors++; $display("FAIL b2b_start_while_busy got %0d exp 0", early); end
        busy_force = 1'b0;
        ns = 0; cyc = 0; c_taken = 1'b0;
        while (ns < 3 && cyc < 80) begin
            accepted = req_valid && req_ready;
            tick(); cyc++;
            if (accepted) begin req_valid = 1'b0; c_taken = 1'b1; end
            if (md_start) begin got_d1[ns] = md_d1; got_cyc[ns] = cyc; ns++; end
        end
        req_valid = 1'b0;
        checks++; if (ns !== 3) begin errors++; $display("FAIL b2b_issue_count got %0d exp 3", ns); end
        checks++; if (c_taken !== 1'b1) begin errors++; $display("FAIL b2b_third_accepted got %b exp 1", c_taken); end
        if (ns == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_d1[i] !== WIDTH'(16'h000A + i)) begin
                    errors++; $display("FAIL b2b_order[%0d] got %h exp %h", i, got_d1[i], 16'h000A + i);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (got_cyc[i] - got_cyc[i-1] !== 8) begin
                    errors++; $display("FAIL b2b_gap[%0d] got %0d exp 8", i, got_cyc[i] - got_cyc[i-1]);
                end
            end
        end
        cyc = 0;
        while (hilo_stall && cyc < 30) begin tick(); cyc++; end
        checks++; if (hilo_stall !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", hilo_stall); end
        $display("back_to_back: %0d issues", ns);
    endtask

    task automatic test_flush();
        int n;
        int starts;
        int bad_stall;
        busy_len = 10;
        req_valid = 1'b1; req_op = MD_OP_MULTU; req_d2 = 16'h0002;
        req_d1 = 16'h00A1; tick();
        req_d1 = 16'h00A2; tick();
        req_d1 = 16'h00A3; tick();
        req_valid = 1'b0; tick();
        checks++; if (q_count !== 2'd2) begin errors++; $display("FAIL flush_pre_count got %0d exp 2", q_count); end
        flush = 1'b1; req_valid = 1'b1; req_d1 = 16'h00A4;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", q_count); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", req_ready); end
        checks++; if (hilo_stall !== 1'b1) begin errors++; $display("FAIL flush_stall_inflight got %b exp 1", hilo_stall); end
        n = 0; starts = 0; bad_stall = 0;
        while (hilo_stall && n < 40) begin
            tick(); n++;
            if (md_start) starts++;
            if (md_busy && !hilo_stall) bad_stall++;
        end
        repeat (5) begin tick(); if (md_start) starts++; end
        checks++; if (starts !== 0) begin errors++; $display("FAIL flush_no_start got %0d exp 0", starts); end
        checks++; if (bad_stall !== 0) begin errors++; $display("FAIL flush_stall_vs_busy got %0d exp 0", bad_stall); end
        checks++; if (hilo_stall !== 1'b0 || q_count !== 2'd0) begin
            errors++; $display("FAIL flush_final got stall=%b count=%0d exp 0/0", hilo_stall, q_count);
        end
        $display("flush: idle after %0d cycles", n);
    endtask

    task automatic test_push_pop();
        int   n;
        logic seen;
        busy_len = 0; busy_force = 1'b1;
        req_valid = 1'b1; req_op = MD_OP_DIV; req_d2 = 16'h0003; req_d1 = 16'h1000;
        tick();
        req_valid = 1'b0;
        checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL pp_setup_count got %0d exp 1", q_count); end
        busy_force = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            req_valid = 1'b1; req_d1 = WIDTH'(16'h1000 + k);
            tick();
            req_valid = 1'b0;
            checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL pp_count[%0d] got %0d exp 1", k, q_count); end
            checks++; if (md_start !== 1'b1 || md_d1 !== WIDTH'(16'h1000 + k - 1)) begin
                errors++; $display("FAIL pp_issue[%0d] got start=%b d1=%h exp 1/%h", k, md_start, md_d1, 16'h1000 + k - 1);
            end
            repeat (3) tick();
        end
        n = 0; seen = 1'b0;
        while (hilo_stall && n < 20) begin
            tick(); n++;
            if (md_start) begin
                seen = 1'b1;
                checks++; if (md_d1 !== 16'h100A) begin errors++; $display("FAIL pp_last_d1 got %h exp 100a", md_d1); end
            end
        end
        checks++; if (seen !== 1'b1 || hilo_stall !== 1'b0) begin
            errors++; $display("FAIL pp_drain got seen=%b stall=%b exp 1/0", seen, hilo_stall);
        end
        $display("push_pop: 10 iterations done");
    endtask

    task automatic test_async_reset();
        busy_len = 5;
        req_valid = 1'b1; req_op = MD_OP_MULT; req_d1 = 16'hBEEF; req_d2 = 16'h1234;
        tick();
`ifndef MDQ_BYPASS_EN
        req_d1 = 16'hCAFE;
        tick();
        checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL rst_pre_count got %0d exp 1", q_count); end
`endif
        req_valid = 1'b0;
        checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL rst_pre_start got %b exp 1", md_start); end
        #2 reset = 1'b0;
        #1;
        checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL rst_async_start got %b exp 0", md_start); end
        checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL rst_async_count got %0d exp 0", q_count); end
        checks++; if ({md_op, md_d1, md_d2} !== 34'd0) begin errors++; $display("FAIL rst_async_regs got %h exp 0", {md_op, md_d1, md_d2}); end
        checks++; if (hilo_stall !== 1'b0) begin errors++; $display("FAIL rst_async_stall got %b exp 0", hilo_stall); end
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        checks++; if (md_start !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_after got start=%b ready=%b exp 0/1", md_start, req_ready);
        end
        $display("async_reset: done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_push_pop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
